imu_fp: RTL and testbench
=========================

IMU_FP -- requirements
Module: imu_fp

Interface
REQ-001 The block SHALL have no parameters; the format is fixed at IEEE-754 binary32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 value  input  32  multiplicand A, binary32 (sign [31], exponent [30:23], mantissa [22:0]).
REQ-005 row  input  32  multiplicand B, binary32, same field layout.
REQ-006 data  output  32  registered product A*B, binary32.

Function
REQ-007 data SHALL be driven directly from a 32-bit register; no combinational path from inputs to data.
REQ-008 Latency SHALL be exactly 1 cycle: inputs sampled at edge N appear on data after edge N.
REQ-009 A new operation SHALL be accepted every cycle; there is no handshake.
REQ-010 Result sign SHALL be value[31] XOR row[31] for all non-NaN results.
REQ-011 An operand with exponent 0 (zero or subnormal) SHALL be treated as signed zero; denormals are flushed on input.
REQ-012 Normal path: product mantissa = {1,mA} * {1,mB}, a 48-bit product; biased exponent = eA + eB - 127.
REQ-013 If product bit 47 is set, shift right 1 and increment the exponent before rounding.
REQ-014 Rounding SHALL be round-to-nearest, ties-to-even, using guard, round and sticky bits from the discarded product bits.
REQ-015 A mantissa carry-out from rounding SHALL renormalize: mantissa becomes 0 and the exponent increments.
REQ-016 Final biased exponent >= 255 SHALL produce signed infinity (exponent 0xFF, mantissa 0).
REQ-017 Final biased exponent <= 0 SHALL produce signed zero; no subnormal outputs.
REQ-018 Either operand NaN (exp 0xFF, mantissa != 0) SHALL produce canonical quiet NaN 0x7FC00000.
REQ-019 Infinity times zero (either order) SHALL produce 0x7FC00000.
REQ-020 Infinity times a nonzero finite value or infinity SHALL produce signed infinity.
REQ-021 Zero times a finite value SHALL produce signed zero (sign per REQ-010).
REQ-022 Special-case priority SHALL be: NaN, then inf*0, then infinity, then zero, then the normal path with overflow/underflow.
REQ-023 No exception flags SHALL be output.

Reset
REQ-024 When rst is high at a rising edge, data SHALL become 0x00000000 and the inputs of that cycle SHALL be discarded.
REQ-025 On the first edge after rst deasserts, data SHALL reflect that edge's inputs; no extra warm-up cycle.
REQ-026 Asserting rst mid-stream SHALL override any pending result in the same edge.

Verification
REQ-027 value=0x40000000 (2.0), row=0x00000000 -> data=0x00000000 one cycle later.
REQ-028 value=0x40000000 (2.0), row=0x3E800000 (0.25) -> data=0x3F000000 (0.5); row=0x3F000000 -> data=0x3F800000 (1.0).
REQ-029 value=0x3FC00000 (1.5), row=0x3FC00000 -> data=0x40100000 (2.25); value=0xBFC00000, same row -> data=0xC0100000.
REQ-030 value=0x7F000000, row=0x40000000 -> data=0x7F800000 (overflow); value=0x00800000, row=0x00800000 -> data=0x00000000 (underflow).
REQ-031 value=0x7F800000, row=0x00000000 -> data=0x7FC00000; value=0x7FC00001, row=0x3F800000 -> data=0x7FC00000; value=0xFF800000, row=0x40000000 -> data=0xFF800000.
REQ-032 Rounding: value=0x3F800001, row=0x3F800001 -> data=0x3F800002. Reset check: rst=1 while valid operands are applied -> data=0x00000000; after rst=0 the result appears one cycle later.

Source files
------------

// File: rtl/imu_fp.sv
// imu_fp: registered binary32 multiplier, RNE rounding, denormals flushed to zero
module imu_fp (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic [31:0] row,
  output logic [31:0] data
);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  logic [31:0] data_d, data_q;
  logic        sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        g, st, up;
  logic [47:0] prod;
  logic [22:0] frac;
  logic [23:0] rnd;
  logic [9:0]  e;
  logic [7:0]  em;
  logic [31:0] inf, zero;
  always_comb begin
    sgn    = value[31] ^ row[31];
    a_nan  = (&value[30:23]) && (|value[22:0]);
    b_nan  = (&row[30:23]) && (|row[22:0]);
    a_inf  = (&value[30:23]) && !(|value[22:0]);
    b_inf  = (&row[30:23]) && !(|row[22:0]);
    a_zero = !(|value[30:23]);
    b_zero = !(|row[30:23]);
    prod   = {24'd0, 1'b1, value[22:0]} * {24'd0, 1'b1, row[22:0]};
    frac   = prod[47] ? prod[46:24] : prod[45:23];
    g      = prod[47] ? prod[23] : prod[22];
    st     = prod[47] ? |prod[22:0] : |prod[21:0];
    up     = g & (st | frac[0]);
    rnd    = {1'b0, frac} + {23'd0, up};
    e      = {2'd0, value[30:23]} + {2'd0, row[30:23]} + {9'd0, prod[47]} + {9'd0, rnd[23]};
    em     = e[7:0] - 8'd127;
    inf    = {sgn, 8'hFF, 23'd0};
    zero   = {sgn, 31'd0};
    data_d = (a_nan || b_nan)                       ? QNAN :
             ((a_inf && b_zero) || (b_inf && a_zero)) ? QNAN :
             (a_inf || b_inf)                       ? inf  :
             (a_zero || b_zero)                     ? zero :
             (e >= 10'd382)                         ? inf  :
             (e <= 10'd127)                         ? zero :
                                                      {sgn, em, rnd[22:0]};
  end
  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end
  assign data = data_q;
endmodule

// File: tb/tb_imu_fp.sv
// tb_imu_fp: table-driven vectors through an expected-result queue for imu_fp
module tb_imu_fp;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value, row, data;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } vec_t;
  vec_t tbl[24];
  imu_fp dut (.clk(clk), .rst(rst), .value(value), .row(row), .data(data));
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] y, input string name);
    logic [31:0] want;
    rst = r;
    value = a;
    row = b;
    exp_q.push_back(y);
    @(posedge clk);
    #1;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, got %08h", name, data);
    end else begin
      want = exp_q.pop_front();
      if (data !== want) begin
        bad++;
        $display("FAIL %s: a=%08h b=%08h got %08h want %08h", name, a, b, data, want);
      end
    end
  endtask
  initial begin
    tbl[0]  = '{32'h40000000, 32'h00000000, 32'h00000000};
    tbl[1]  = '{32'h40000000, 32'h3E800000, 32'h3F000000};
    tbl[2]  = '{32'h40000000, 32'h3F000000, 32'h3F800000};
    tbl[3]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000};
    tbl[4]  = '{32'hBFC00000, 32'h3FC00000, 32'hC0100000};
    tbl[5]  = '{32'h7F000000, 32'h40000000, 32'h7F800000};
    tbl[6]  = '{32'h00800000, 32'h00800000, 32'h00000000};
    tbl[7]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000};
    tbl[8]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000};
    tbl[9]  = '{32'hFF800000, 32'h40000000, 32'hFF800000};
    tbl[10] = '{32'h3F800001, 32'h3F800001, 32'h3F800002};
    tbl[11] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002};
    tbl[12] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004};
    tbl[13] = '{32'h3F800400, 32'h3FFFF800, 32'h40000000};
    tbl[14] = '{32'h80000000, 32'h40000000, 32'h80000000};
    tbl[15] = '{32'h00000001, 32'hFF000000, 32'h80000000};
    tbl[16] = '{32'h00000000, 32'hFF800000, 32'h7FC00000};
    tbl[17] = '{32'h3F800000, 32'hFF800001, 32'h7FC00000};
    tbl[18] = '{32'hFF800000, 32'h7F800000, 32'hFF800000};
    tbl[19] = '{32'hFF800000, 32'h7FC00000, 32'h7FC00000};
    tbl[20] = '{32'h3F800000, 32'h00800000, 32'h00800000};
    tbl[21] = '{32'h3F000000, 32'h00800000, 32'h00000000};
    tbl[22] = '{32'h7F7FFFFF, 32'hBF800000, 32'hFF7FFFFF};
    tbl[23] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE};
    rst = 1'b1;
    value = '0;
    row = '0;
    @(negedge clk);
    step(1'b1, 32'h3FC00000, 32'h3FC00000, 32'h00000000, "reset_state");
    step(1'b0, 32'h40000000, 32'h3E800000, 32'h3F000000, "first_after_reset");
    for (int i = 0; i < 24; i++) step(1'b0, tbl[i].a, tbl[i].b, tbl[i].y, $sformatf("vec%0d", i));
    step(1'b1, 32'h3FC00000, 32'h3FC00000, 32'h00000000, "midstream_reset");
    step(1'b1, 32'h40000000, 32'h3F000000, 32'h00000000, "reset_held");
    step(1'b0, 32'h3FC00000, 32'h3FC00000, 32'h40100000, "resume_0");
    step(1'b0, 32'hBFC00000, 32'h3FC00000, 32'hC0100000, "resume_1");
    step(1'b0, 32'hFF800000, 32'h80000000, 32'h7FC00000, "resume_2");
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d leftover want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
